alu_serial_ctrl: RTL

Bit-serial sequencer that runs a full 32-bit ALU operation through a single 1-bit ALU slice, one bit per clock, LSB first. It decodes the 4-bit ALU control into the slice's A_invert / B_invert / operation / cin controls. It carries the ripple carry between cycles and resolves SLT from the MSB set bit. It sits between the CPU's ALU-control decode and the register write-back path, giving an area-minimal multi-cycle ALU.

---
 rtl/alu_serial_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
// Purpose : bit-serial 32-bit ALU sequencer driving one 1-bit slice, LSB first, with SLT resolve.
// Latency : done_o pulses 33 cycles after the accepting edge; result/flags held until next start.
// Backpr. : start_i is only sampled in IDLE; a start while busy is dropped, never queued.
//
// Ports:
//   clk_i, rst_n       clock (rising edge), synchronous active-low reset
//   start_i            operation request, accepted when busy_o=0
//   src1_i, src2_i     operands A/B, captured on the accepted start
//   ALU_control_i      4-bit operation code, captured on the accepted start
//   busy_o, done_o     sequencer status; done_o is a one-cycle pulse
//   result_o, zero_o   result register and its zero detect
//   cout_o, overflow_o carry out / signed overflow of the top bit (arithmetic ops only)
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Slice operation select
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic             a_inv_q, a_inv_d;
  logic             b_inv_q, b_inv_d;
  logic [1:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  // Control decode of the incoming opcode
  logic       dec_a_inv;
  logic       dec_b_inv;
  logic [1:0] dec_op;
  logic       dec_cin;
  logic       dec_illegal;

  always_comb begin
    dec_a_inv   = 1'b0;
    dec_b_inv   = 1'b0;
    dec_op      = OP_AND;
    dec_cin     = 1'b0;
    dec_illegal = 1'b0;
    case (ALU_control_i)
      4'b0000: dec_op = OP_AND;
      4'b0001: dec_op = OP_OR;
      4'b0010: dec_op = OP_SUM;
      4'b0110: begin
        dec_b_inv = 1'b1;
        dec_op    = OP_SUM;
        dec_cin   = 1'b1;
      end
      4'b0111: begin
        dec_b_inv = 1'b1;
        dec_op    = OP_LESS;
        dec_cin   = 1'b1;
      end
      4'b1100: begin
        dec_a_inv = 1'b1;
        dec_b_inv = 1'b1;
        dec_op    = OP_AND;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // 1-bit ALU slice
  logic slice_a;
  logic slice_b;
  logic sum_bit;
  logic carry_nxt;
  logic slice_out;
  logic is_last;
  logic arith;
  logic ovf_bit;

  always_comb begin
    slice_a   = src1_q[cnt_q] ^ a_inv_q;
    slice_b   = src2_q[cnt_q] ^ b_inv_q;
    sum_bit   = slice_a ^ slice_b ^ carry_q;
    carry_nxt = (slice_a & slice_b) | (slice_a & carry_q) | (slice_b & carry_q);
    case (op_q)
      OP_AND:  slice_out = slice_a & slice_b;
      OP_OR:   slice_out = slice_a | slice_b;
      OP_SUM:  slice_out = sum_bit;
      default: slice_out = 1'b0;  // SLT "less" input; real bit fixed up on the MSB
    endcase
    is_last = (cnt_q == CNT_LAST);
    arith   = op_q[1] & ~illegal_q;
    // Overflow is carry into the MSB xor carry out of it
    ovf_bit = carry_q ^ carry_nxt;
  end

  always_comb begin
    state_d    = state_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    a_inv_d    = a_inv_q;
    b_inv_d    = b_inv_q;
    op_d       = op_q;
    illegal_d  = illegal_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src1_d     = src1_i;
          src2_d     = src2_i;
          a_inv_d    = dec_a_inv;
          b_inv_d    = dec_b_inv;
          op_d       = dec_op;
          illegal_d  = dec_illegal;
          carry_d    = dec_cin;
          cnt_d      = '0;
          cout_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        result_d = {slice_out, result_q[WIDTH-1:1]};
        carry_d  = carry_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (is_last) begin
          cout_d     = arith & carry_nxt;
          overflow_d = arith & ovf_bit;
          if (illegal_q) begin
            result_d = '0;
          end else if (op_q == OP_LESS) begin
            // Sign of the true difference: sum MSB corrected by overflow
            result_d = {{(WIDTH-1){1'b0}}, sum_bit ^ ovf_bit};
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      a_inv_q    <= 1'b0;
      b_inv_q    <= 1'b0;
      op_q       <= OP_AND;
      illegal_q  <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      a_inv_q    <= a_inv_d;
      b_inv_q    <= b_inv_d;
      op_q       <= op_d;
      illegal_q  <= illegal_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign result_o   = result_q;
  assign zero_o     = (result_q == '0);
  assign cout_o     = cout_q;
  assign overflow_o = overflow_q;

endmodule
